// File: rtl/hft_pkg.sv
// Shared definitions for the feed arbiter, the message parser and their benches.
package hft_pkg;

    localparam int MSG_WORDS = 9;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FLUSH   = 2'd2,
        EMIT    = 2'd3
    } arb_state_t;

    localparam logic [7:0] MSG_TYPE_ADD     = 8'h41;
    localparam logic [7:0] MSG_TYPE_DELETE  = 8'h44;
    localparam logic [7:0] MSG_TYPE_EXECUTE = 8'h45;

    typedef enum logic [1:0] {
        ORDER_NONE    = 2'd0,
        ORDER_ADD     = 2'd1,
        ORDER_DELETE  = 2'd2,
        ORDER_EXECUTE = 2'd3
    } order_t;

    typedef enum logic {
        TRADE_BUY  = 1'b0,
        TRADE_SELL = 1'b1
    } trade_t;

    typedef enum logic [1:0] {
        STOCK_NONE  = 2'd0,
        STOCK_AAPL  = 2'd1,
        STOCK_MSFT  = 2'd2,
        STOCK_OTHER = 2'd3
    } stock_t;

    // Word 0 of a message: locate code 0x01 in byte 1, message type in byte 0.
    function automatic logic [31:0] msg_header(input logic [7:0] msg_type);
        return {24'h00_0001, msg_type};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Cyclic priority search: grants the first requester at or after ptr_i.
module rr_arbiter #(
    parameter  int N  = 2,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);

    int            best_s;
    int            dist_s;
    logic          take_s;
    logic [IW-1:0] idx_s;

    // Pick the requester with the smallest cyclic distance from the pointer.
    always_comb begin
        best_s = N;
        dist_s = 0;
        take_s = 1'b0;
        idx_s  = '0;
        for (int j = 0; j < N; j++) begin
            dist_s = (j >= int'(ptr_i)) ? (j - int'(ptr_i)) : (j - int'(ptr_i) + N);
            take_s = req_i[j] && (dist_s < best_s);
            best_s = take_s ? dist_s : best_s;
            idx_s  = take_s ? IW'(j) : idx_s;
        end
    end

    // Expand the winning index into a one-hot grant (all zero when nobody requests).
    always_comb begin
        gnt_o = '0;
        for (int j = 0; j < N; j++) begin
            gnt_o[j] = (best_s < N) && (idx_s == IW'(j));
        end
    end

    assign idx_o = idx_s;

endmodule

// File: rtl/parser_feed_arbiter.sv
// Shares one message parser between several serial feeds: locks a feed for a whole
// message, assembles its words, emits well-formed messages and drops malformed ones.
module parser_feed_arbiter
    import hft_pkg::*;
#(
    parameter  int NUM_FEEDS = 2,
    parameter  int REG_WIDTH = 32,
    parameter  int MSG_WORDS = hft_pkg::MSG_WORDS,
    parameter  int CNT_WIDTH = 16,
    localparam int IW        = $clog2(NUM_FEEDS)
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic [NUM_FEEDS-1:0]           i_feed_valid,
    input  logic [NUM_FEEDS*REG_WIDTH-1:0] i_feed_data,
    input  logic [NUM_FEEDS-1:0]           i_feed_last,
    output logic [NUM_FEEDS-1:0]           o_feed_ready,
    output logic [MSG_WORDS*REG_WIDTH-1:0] o_msg_words,
    output logic                           o_msg_valid,
    output logic [IW-1:0]                  o_msg_src,
    output logic [CNT_WIDTH-1:0]           o_drop_count,
    output logic                           o_err
);

    localparam int WCW = $clog2(MSG_WORDS);
    localparam int SW  = $clog2(MSG_WORDS - 1);

    arb_state_t                     state_q;
    logic [IW-1:0]                  rr_ptr_q;
    logic [IW-1:0]                  grant_q;
    logic [IW-1:0]                  msg_src_q;
    logic [NUM_FEEDS-1:0]           ready_q;
    logic [WCW-1:0]                 word_cnt_q;
    logic [REG_WIDTH-1:0]           staging_q [MSG_WORDS-1];
    logic [MSG_WORDS*REG_WIDTH-1:0] msg_words_q;
    logic                           msg_valid_q;
    logic                           err_q;
    logic [CNT_WIDTH-1:0]           drop_count_q;

    logic [NUM_FEEDS-1:0]           arb_gnt_s;
    logic [IW-1:0]                  arb_idx_s;
    logic [IW-1:0]                  rr_ptr_d;
    logic [CNT_WIDTH-1:0]           drop_count_d;
    logic [REG_WIDTH-1:0]           data_s;
    logic                           xfer_s;
    logic                           last_s;
    logic                           final_word_s;

    rr_arbiter #(.N(NUM_FEEDS)) u_rr (
        .req_i (i_feed_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (arb_gnt_s),
        .idx_o (arb_idx_s)
    );

    // ready_q only ever carries the granted feed's bit, so this is the granted handshake.
    assign xfer_s       = |(i_feed_valid & ready_q);
    assign data_s       = i_feed_data[int'(grant_q)*REG_WIDTH +: REG_WIDTH];
    assign last_s       = i_feed_last[grant_q];
    assign final_word_s = (word_cnt_q == WCW'(MSG_WORDS - 1));
    assign rr_ptr_d     = (grant_q == IW'(NUM_FEEDS - 1)) ? '0 : grant_q + IW'(1);
    assign drop_count_d = (&drop_count_q) ? drop_count_q : drop_count_q + CNT_WIDTH'(1);

    // Arbitration / collection FSM with all outputs registered.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            msg_src_q    <= '0;
            ready_q      <= '0;
            word_cnt_q   <= '0;
            msg_words_q  <= '0;
            msg_valid_q  <= 1'b0;
            err_q        <= 1'b0;
            drop_count_q <= '0;
            for (int n = 0; n < MSG_WORDS - 1; n++) begin
                staging_q[n] <= '0;
            end
        end else begin
            msg_valid_q <= 1'b0;
            err_q       <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|i_feed_valid) begin
                        grant_q    <= arb_idx_s;
                        ready_q    <= arb_gnt_s;
                        word_cnt_q <= '0;
                        state_q    <= COLLECT;
                    end else begin
                        ready_q <= '0;
                    end
                end
                COLLECT: begin
                    if (xfer_s) begin
                        if (!final_word_s) begin
                            staging_q[SW'(word_cnt_q)] <= data_s;
                        end
                        if (last_s && final_word_s) begin
                            // The final word goes straight to the output bank.
                            for (int n = 0; n < MSG_WORDS - 1; n++) begin
                                msg_words_q[n*REG_WIDTH +: REG_WIDTH] <= staging_q[n];
                            end
                            msg_words_q[(MSG_WORDS-1)*REG_WIDTH +: REG_WIDTH] <= data_s;
                            msg_src_q   <= grant_q;
                            msg_valid_q <= 1'b1;
                            ready_q     <= '0;
                            state_q     <= EMIT;
                        end else if (last_s) begin
                            err_q        <= 1'b1;
                            drop_count_q <= drop_count_d;
                            rr_ptr_q     <= rr_ptr_d;
                            ready_q      <= '0;
                            state_q      <= IDLE;
                        end else if (final_word_s) begin
                            state_q <= FLUSH;
                        end else begin
                            word_cnt_q <= word_cnt_q + WCW'(1);
                        end
                    end
                end
                FLUSH: begin
                    if (xfer_s && last_s) begin
                        err_q        <= 1'b1;
                        drop_count_q <= drop_count_d;
                        rr_ptr_q     <= rr_ptr_d;
                        ready_q      <= '0;
                        state_q      <= IDLE;
                    end
                end
                EMIT: begin
                    rr_ptr_q <= rr_ptr_d;
                    state_q  <= IDLE;
                end
                default: begin
                    ready_q <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_feed_ready = ready_q;
    assign o_msg_words  = msg_words_q;
    assign o_msg_valid  = msg_valid_q;
    assign o_msg_src    = msg_src_q;
    assign o_drop_count = drop_count_q;
    assign o_err        = err_q;

endmodule

// File: tb/tb_parser_feed_arbiter.sv
// Directed and random message streams on three feeds, checked against a
// message-level round-robin model of grant order, emitted words and drops.
module tb_parser_feed_arbiter;
    import hft_pkg::*;

    localparam int NF      = 3;
    localparam int RW      = 32;
    localparam int MW      = 9;
    localparam int CW      = 3;
    localparam int IW      = $clog2(NF);
    localparam int DROPMAX = (1 << CW) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [NF-1:0]    fv;
    logic [NF*RW-1:0] fd;
    logic [NF-1:0]    fl;
    logic [NF-1:0]    o_feed_ready;
    logic [MW*RW-1:0] o_msg_words;
    logic             o_msg_valid;
    logic [IW-1:0]    o_msg_src;
    logic [CW-1:0]    o_drop_count;
    logic             o_err;

    always #5 clk = ~clk;

    parser_feed_arbiter #(.NUM_FEEDS(NF), .REG_WIDTH(RW), .MSG_WORDS(MW), .CNT_WIDTH(CW)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_feed_valid (fv),
        .i_feed_data  (fd),
        .i_feed_last  (fl),
        .o_feed_ready (o_feed_ready),
        .o_msg_words  (o_msg_words),
        .o_msg_valid  (o_msg_valid),
        .o_msg_src    (o_msg_src),
        .o_drop_count (o_drop_count),
        .o_err        (o_err)
    );

    int total = 0;
    int bad   = 0;

    // feed driver state: entry = {gap[6:0], last, data[31:0]}
    logic [39:0] fq [NF][$];
    int          gap_cnt [NF];
    bit          fresh [NF];
    bit          acc_pend [NF];
    bit          xfer_last_pend;
    int          acc_total;
    int          cyc;

    // message store and pending phase
    logic [31:0] wbuf [$];
    int          gbuf [$];
    int          pm_feed [$];
    int          pm_base [$];
    int          pm_len [$];
    int          mq [NF][$];

    // expected events: kind 0 = emit, 1 = drop
    int exp_kind [$];
    int exp_src [$];
    int exp_base [$];
    int exp_drop [$];

    int rr_m, drop_m, last_emit_base;
    bit period_chk;
    int last_valid_cyc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic flush_driver();
        for (int k = 0; k < NF; k++) begin
            fq[k].delete();
            gap_cnt[k]  = 0;
            fresh[k]    = 1'b1;
            acc_pend[k] = 1'b0;
        end
        fv = '0;
        fl = '0;
        fd = '0;
        xfer_last_pend = 1'b0;
    endtask

    // One clock: check DUT outputs at the negedge, then drive the feeds.
    task automatic tick();
        int kind, src, base, drop;
        logic [31:0] ew;
        @(negedge clk);
        if (!rst) begin
            check("ready_onehot0", 64'($onehot0(o_feed_ready)), 64'd1);
            if (!period_chk) last_valid_cyc = -1;
            if (o_msg_valid || o_err) begin
                if (exp_kind.size() == 0) begin
                    check("unexpected_event", {62'd0, o_msg_valid, o_err}, 64'd0);
                end else begin
                    kind = exp_kind.pop_front();
                    src  = exp_src.pop_front();
                    base = exp_base.pop_front();
                    drop = exp_drop.pop_front();
                    check("event_kind", {62'd0, o_msg_valid, o_err}, (kind == 0) ? 64'd2 : 64'd1);
                    check("event_latency", 64'(xfer_last_pend), 64'd1);
                    check("drop_count", 64'(o_drop_count), 64'(drop));
                    if (kind == 0) check("msg_src", 64'(o_msg_src), 64'(src));
                    for (int n = 0; n < MW; n++) begin
                        ew = (base < 0) ? 32'd0 : wbuf[base+n];
                        check($sformatf("msg_word%0d", n), 64'(o_msg_words[n*RW +: RW]), 64'(ew));
                    end
                    if (o_msg_valid && period_chk && last_valid_cyc >= 0)
                        check("msg_period", 64'(cyc - last_valid_cyc), 64'd11);
                    if (o_msg_valid) last_valid_cyc = cyc;
                end
            end
        end
        for (int k = 0; k < NF; k++) begin
            if (acc_pend[k] && fq[k].size() > 0) begin
                void'(fq[k].pop_front());
                acc_total++;
                fresh[k] = 1'b1;
            end
            if (fresh[k] && fq[k].size() > 0) begin
                gap_cnt[k] = int'(fq[k][0][39:33]);
                fresh[k]   = 1'b0;
            end
            if (fq[k].size() > 0 && gap_cnt[k] == 0) begin
                fv[k]          = 1'b1;
                fl[k]          = fq[k][0][32];
                fd[k*RW +: RW] = fq[k][0][31:0];
            end else begin
                fv[k] = 1'b0;
                fl[k] = 1'b0;
                if (gap_cnt[k] > 0) gap_cnt[k]--;
            end
            acc_pend[k] = fv[k] && o_feed_ready[k];
        end
        xfer_last_pend = 1'b0;
        for (int k = 0; k < NF; k++) if (acc_pend[k] && fl[k]) xfer_last_pend = 1'b1;
        cyc++;
    endtask

    task automatic add_msg(input int f, input int len, input logic [7:0] typ, input bit rgap, output int base);
        base = wbuf.size();
        for (int w = 0; w < len; w++) begin
            wbuf.push_back((w == 0) ? msg_header(typ) : $urandom);
            gbuf.push_back((rgap && w > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
        end
        pm_feed.push_back(f);
        pm_base.push_back(base);
        pm_len.push_back(len);
    endtask

    // Message-level model: each round serves the first feed with work from rr_m onwards.
    task automatic run_phase();
        int g, i, k;
        bit more;
        for (int f = 0; f < NF; f++) mq[f].delete();
        for (int j = 0; j < pm_feed.size(); j++) mq[pm_feed[j]].push_back(j);
        more = 1'b1;
        while (more) begin
            g = -1;
            for (int s = 0; s < NF; s++) begin
                k = (rr_m + s) % NF;
                if (g < 0 && mq[k].size() > 0) g = k;
            end
            if (g < 0) begin
                more = 1'b0;
            end else begin
                i = mq[g].pop_front();
                if (pm_len[i] == MW) begin
                    exp_kind.push_back(0); exp_src.push_back(g);
                    exp_base.push_back(pm_base[i]); exp_drop.push_back(drop_m);
                    last_emit_base = pm_base[i];
                end else begin
                    drop_m = (drop_m < DROPMAX) ? drop_m + 1 : drop_m;
                    exp_kind.push_back(1); exp_src.push_back(g);
                    exp_base.push_back(last_emit_base); exp_drop.push_back(drop_m);
                end
                rr_m = (g + 1) % NF;
            end
        end
        for (int j = 0; j < pm_feed.size(); j++) begin
            for (int w = 0; w < pm_len[j]; w++) begin
                fq[pm_feed[j]].push_back({(w == 0) ? 7'd0 : 7'(gbuf[pm_base[j]+w]),
                                          (w == pm_len[j] - 1), wbuf[pm_base[j]+w]});
            end
        end
        pm_feed.delete(); pm_base.delete(); pm_len.delete();
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        bit busy;
        n = 0;
        busy = 1'b1;
        while (busy && n < budget) begin
            tick();
            n++;
            busy = (exp_kind.size() != 0);
            for (int k = 0; k < NF; k++) if (fq[k].size() != 0) busy = 1'b1;
        end
        check(tag, 64'(busy), 64'd0);
        repeat (4) tick();
    endtask

    initial begin
        int b, start, n;
        rst = 1'b1;
        cyc = 0; acc_total = 0;
        rr_m = 0; drop_m = 0; last_emit_base = -1;
        period_chk = 1'b0; last_valid_cyc = -1;
        flush_driver();
        tick(); tick();
        check("rst_ready", 64'(o_feed_ready), 64'd0);
        check("rst_words", 64'(|o_msg_words), 64'd0);
        check("rst_valid", 64'(o_msg_valid), 64'd0);
        check("rst_src", 64'(o_msg_src), 64'd0);
        check("rst_drop", 64'(o_drop_count), 64'd0);
        check("rst_err", 64'(o_err), 64'd0);
        rst = 1'b0;
        tick();

        // single add message on feed 0
        add_msg(0, MW, MSG_TYPE_ADD, 1'b0, b);
        wbuf[b+6] = 32'h2020_2020;
        wbuf[b+7] = 32'h4141_504C;
        wbuf[b+8] = 32'd150;
        run_phase();
        wait_idle("drain_single", 200);

        // back-to-back alternating messages at full rate
        period_chk = 1'b1;
        for (int r = 0; r < 2; r++) begin
            add_msg(0, MW, MSG_TYPE_ADD, 1'b0, b);
            add_msg(1, MW, MSG_TYPE_EXECUTE, 1'b0, b);
        end
        run_phase();
        wait_idle("drain_b2b", 300);
        period_chk = 1'b0;

        // short message on feed 1, then feed 0 must win the next round
        add_msg(1, 5, MSG_TYPE_DELETE, 1'b0, b);
        add_msg(1, MW, MSG_TYPE_ADD, 1'b0, b);
        add_msg(0, MW, MSG_TYPE_ADD, 1'b0, b);
        run_phase();
        wait_idle("drain_short", 300);

        // long message on feed 0
        add_msg(0, 12, MSG_TYPE_ADD, 1'b0, b);
        run_phase();
        wait_idle("drain_long", 200);

        // reset after four words of a message
        start = acc_total;
        for (int w = 0; w < MW; w++)
            fq[0].push_back({(w == 4) ? 7'd20 : 7'd0, (w == MW - 1), 32'hDEAD_0000 + 32'(w)});
        n = 0;
        while (acc_total < start + 4 && n < 100) begin
            tick();
            n++;
        end
        check("reset_words_before", 64'(acc_total - start), 64'd4);
        rst = 1'b1;
        #1;
        check("midrst_ready", 64'(o_feed_ready), 64'd0);
        check("midrst_words", 64'(|o_msg_words), 64'd0);
        check("midrst_valid", 64'(o_msg_valid), 64'd0);
        check("midrst_src", 64'(o_msg_src), 64'd0);
        check("midrst_drop", 64'(o_drop_count), 64'd0);
        check("midrst_err", 64'(o_err), 64'd0);
        flush_driver();
        rr_m = 0; drop_m = 0; last_emit_base = -1;
        tick();
        rst = 1'b0;
        add_msg(1, MW, MSG_TYPE_ADD, 1'b0, b);
        add_msg(0, MW, MSG_TYPE_EXECUTE, 1'b0, b);
        run_phase();
        wait_idle("drain_after_reset", 300);

        // three-cycle valid gap between w3 and w4
        add_msg(0, MW, MSG_TYPE_ADD, 1'b0, b);
        gbuf[b+4] = 3;
        run_phase();
        wait_idle("drain_gap", 200);

        // enough drops to saturate the counter
        for (int m = 0; m < 10; m++) add_msg(m % NF, 1 + (m % 4), MSG_TYPE_DELETE, 1'b0, b);
        run_phase();
        wait_idle("drain_saturate", 400);
        check("drop_saturated", 64'(o_drop_count), 64'(DROPMAX));

        // random traffic on all feeds
        for (int m = 0; m < 30; m++) begin
            n = int'($urandom_range(0, 9));
            add_msg(int'($urandom_range(0, NF - 1)),
                    (n < 6) ? MW : (n < 8) ? int'($urandom_range(1, MW - 1)) : int'($urandom_range(MW + 1, 13)),
                    MSG_TYPE_ADD, 1'b1, b);
        end
        run_phase();
        wait_idle("drain_random", 3000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/parser_feed_arbiter.md
Name: parser_feed_arbiter

Overview:
Round-robin scheduler that shares the single message parser between NUM_FEEDS serial feed sources. Each feed streams one 32-bit word per beat, with valid/ready/last signalling. The block locks a grant to one feed for a whole 9-word message and assembles the words into the parser's register bank. It then pulses the parser's data-valid for one cycle. Malformed messages (wrong word count) are discarded and counted; the parser never sees them.

Parameters:
NUM_FEEDS, 2, number of requesting feeds (2..8)
REG_WIDTH, 32, word width, equal to the parser register width
MSG_WORDS, 9, words per message (parser regs 0..8)
CNT_WIDTH, 16, width of the drop counter

Ports:
i_clk  in  1  clock
i_reset  in  1  asynchronous active-high reset
i_feed_valid  in  NUM_FEEDS  per-feed word valid
i_feed_data  in  NUM_FEEDS*REG_WIDTH  per-feed word; feed k occupies bits [k*REG_WIDTH +: REG_WIDTH]
i_feed_last  in  NUM_FEEDS  per-feed last-word marker
o_feed_ready  out  NUM_FEEDS  per-feed ready; one-hot or zero
o_msg_words  out  MSG_WORDS*REG_WIDTH  assembled message; word n at [n*REG_WIDTH +: REG_WIDTH]; wired to parser i_reg_n
o_msg_valid  out  1  one-cycle pulse to parser i_data_valid
o_msg_src  out  $clog2(NUM_FEEDS)  feed index of the message in o_msg_words
o_drop_count  out  CNT_WIDTH  malformed messages discarded, saturating
o_err  out  1  one-cycle pulse per discarded message

Behaviour:
- Reset (asynchronous, i_reset=1): state=IDLE; rr_ptr=0; word_cnt=0; grant=0. All outputs are 0: o_feed_ready, o_msg_words, o_msg_valid, o_msg_src, o_drop_count, o_err. Reset mid-message discards the partial message with no o_err and no count.
- Handshake: a word transfers when i_feed_valid[g] && o_feed_ready[g]. Only the granted feed g sees ready=1. Feeds hold data/valid/last until they are accepted.
- States:
  - IDLE: o_feed_ready=0. If any i_feed_valid is set, choose g = the first requesting feed at or after rr_ptr (cyclic search), latch grant=g, word_cnt=0, and go to COLLECT. If no feed is valid, stay in IDLE.
  - COLLECT: o_feed_ready[g]=1. On each transfer, staging[word_cnt] <= data and word_cnt increments.
    - Transfer with last=1 and word_cnt==MSG_WORDS-1: copy staging (including the current word) into o_msg_words, set o_msg_src=g, go to EMIT.
    - Transfer with last=1 and word_cnt<MSG_WORDS-1 (short message): pulse o_err, increment o_drop_count, set rr_ptr=g+1 mod NUM_FEEDS, go to IDLE.
    - Transfer with last=0 and word_cnt==MSG_WORDS-1 (long message): go to FLUSH.
  - FLUSH: o_feed_ready[g]=1. Discard words until a transfer with last=1. Then pulse o_err, increment o_drop_count, set rr_ptr=g+1, go to IDLE.
  - EMIT: o_msg_valid=1 for exactly this cycle. o_feed_ready=0. Set rr_ptr=g+1 mod NUM_FEEDS, go to IDLE.
- Latency and throughput:
  - o_msg_valid is asserted 1 cycle after the accepting edge of the final word.
  - Minimum message period is MSG_WORDS+2 cycles (IDLE + 9 COLLECT + EMIT).
- o_msg_words and o_msg_src are registered. They hold their value from the EMIT copy until the next successful EMIT. Partial or dropped messages never change them.
- Fairness: the feed just served gets the lowest priority next round, including on drops. A feed asserting valid continuously is served at least once every NUM_FEEDS messages.
- Grant is locked for the whole message. Valid from other feeds during COLLECT/FLUSH is ignored; those feeds are not accepted.
- o_drop_count saturates at all-ones. o_err still pulses when it is saturated.
- Valid on the granted feed may deassert between words. word_cnt holds and nothing times out.

Decomposition:
- Shared package hft_pkg holds:
  - MSG_WORDS = 9.
  - The arbiter state enum {IDLE, COLLECT, FLUSH, EMIT}.
  - The message type codes 8'h41 (add), 8'h44 (delete), 8'h45 (execute), for benches.
  - The parser's order_t, trade_t and stock_t enums, moved here so parser and bench share them.
- One sub-module, rr_arbiter: combinational cyclic priority search. Inputs are the request vector and rr_ptr; outputs are a one-hot grant and its index.

Test Plan:
- Feed0 sends a 9-word add message: w0=32'h0000_0141, w6=32'h2020_2020, w7=32'h4141_504C, w8=32'd150, with last on w8 → one o_msg_valid pulse 1 cycle after w8 is accepted. o_msg_words word0=0x141, word7=0x4141504C, word8=150; o_msg_src=0.
- Feed0 and feed1 both hold valid with back-to-back messages → grants alternate 0,1,0,1. Each o_msg_valid carries the matching o_msg_src. The period is 11 cycles.
- Feed1 asserts last on its 5th word → o_err pulses once, o_drop_count=1, o_msg_valid stays 0, o_msg_words is unchanged from the previous message. The next grant goes to feed0 when feed0 is requesting.
- Feed0 sends 12 words with last on w11 → all 12 are accepted. o_err pulses on w11, o_drop_count increments, and there is no o_msg_valid.
- Assert i_reset for 1 cycle after 4 words of a message → all outputs are 0 immediately, no o_err. The next full message is emitted correctly.
- Feed0 deasserts valid for 3 cycles between w3 and w4 → the message is assembled intact and o_msg_valid fires once.
